player_req_ctrl: RTL and testbench
==================================

Name: player_req_ctrl

Overview:
Player-side requester for the two-player arbiter game; one instance per pushbutton.
- Synchronises and debounces the raw active-low button.
- Times the reaction from the end of the countdown.
- Drives a latched request toward the arbiter FSM and holds it until the game resolves.
- Reports the player outcome: won, lost or false start.

Parameters:
CLOCK_FREQ, 12000000, clk frequency in Hz
DEBOUNCE_CYCLES, CLOCK_FREQ/50, consecutive stable cycles required to accept a new button level (20 ms)
TICK_CYCLES, CLOCK_FREQ/1000, clk cycles per reaction-time tick (1 ms)
RT_WIDTH, 10, width of the reaction-time result

Ports:
clk  in  1  system clock
rst_in_n  in  1  reset, asynchronous, active-low
btn_in_n  in  1  raw pushbutton, active-low, asynchronous to clk
arm_in  in  1  one-cycle pulse: countdown finished, presses now count
gnt_in  in  1  grant to this player from arbiter
done_in  in  1  game resolved (either player granted)
clear_in  in  1  synchronous return to IDLE
req_out  out  1  request to arbiter
btn_level_out  out  1  debounced level, 1 = pressed
rt_ms_out  out  RT_WIDTH  latched reaction time in ticks
rt_valid_out  out  1  rt_ms_out holds a captured value
won_out  out  1  player won
lost_out  out  1  player lost
false_start_out  out  1  pressed before arm

Behaviour:
- Reset: all outputs are 0, state is IDLE, both sync flops are 1 (released), and all counters are 0.
- Synchroniser: 2-FF chain on btn_in_n. The synchronised value is inverted to form the "pressed" level.
- Debounce counter:
  - Increments each cycle the synchronised level differs from btn_level_out.
  - Clears on any cycle it matches.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, btn_level_out toggles on the next edge and the counter clears.
  - Latency from a raw edge to btn_level_out is 2 + DEBOUNCE_CYCLES cycles.
- Press edge: internal one-cycle pulse, registered, asserted the cycle after btn_level_out goes 0->1. Release edges do nothing.
- Tick prescaler: counts 0..TICK_CYCLES-1 in ARMED only; zeroed on entry to ARMED.
- ms counter:
  - Increments on prescaler wrap.
  - Saturates at 2^RT_WIDTH-1 (no wrap).
  - Zeroed on arm.
- States: IDLE, ARMED, REQ, WON, LOST, FOUL. Transitions are evaluated in priority order:
  - Any state, clear_in -> IDLE. Clears rt_valid_out, rt_ms_out and the counters. clear_in beats every other event in the same cycle.
  - IDLE:
    - press edge -> FOUL (see optional feature).
    - else arm_in -> ARMED.
    - gnt_in and done_in are ignored.
  - ARMED:
    - done_in -> LOST. Opponent won first; if a press edge arrives in the same cycle, done_in wins.
    - else press edge -> REQ. rt_ms_out <= current ms count; rt_valid_out <= 1.
    - gnt_in is ignored.
  - REQ:
    - gnt_in -> WON. gnt_in together with done_in -> WON.
    - else done_in -> LOST.
    - Button release does not drop the request.
  - WON, LOST, FOUL: hold until clear_in. Presses, arm_in, gnt_in and done_in are ignored.
- Outputs are registered and decoded from state:
  - req_out = (state==REQ).
  - won_out, lost_out and false_start_out are high in WON, LOST and FOUL respectively.
  - rt_valid_out stays 1 through WON/LOST once captured.
- arm_in outside IDLE is ignored.
- Asynchronous reset mid-game returns to the reset values immediately, with no pending request.

Optional Feature:
PLAYER_FALSE_START_EN
- Defined: a press edge in IDLE enters FOUL and asserts false_start_out.
- Undefined: press edges in IDLE are ignored. FOUL is unreachable, false_start_out is tied 0 and its logic is removed.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=10, RT_WIDTH=4.
1. Bounce: btn_in_n toggles every 2 cycles for 20 cycles, then held 0 -> btn_level_out rises exactly 6 cycles after the final stable edge; no earlier glitch.
2. Win: arm_in pulse, press settles so the press edge occurs 35 cycles after arm, gnt_in pulse 3 cycles later -> req_out=1 in REQ, rt_ms_out=3, rt_valid_out=1, won_out=1, req_out=0 once in WON.
3. Loss race: in ARMED, press edge and done_in in the same cycle -> LOST, req_out never 1, rt_valid_out=0. Separately, REQ then done_in with gnt_in=0 -> lost_out=1 and rt_valid_out stays 1.
4. Saturation: arm, no press for 200 cycles, then press -> rt_ms_out=15.
5. False start: press in IDLE -> false_start_out=1 with the macro defined; without it, the state stays IDLE and a later arm+press reaches REQ normally.
6. Clear/reset priority: clear_in with gnt_in in REQ -> IDLE and all status 0. rst_in_n low mid-REQ -> req_out=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/player_req_ctrl.sv
// Player requester: sync + debounce button, time reaction from arm, latch request until resolved.
// Latency: raw edge -> btn_level_out 2+DEBOUNCE_CYCLES clk; press edge -> req_out 2 further clk.
// Backpressure: none; request is held until gnt_in/done_in/clear_in. Optional macro: PLAYER_FALSE_START_EN.
module player_req_ctrl #(
    parameter int CLOCK_FREQ      = 12000000,
    parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 50,
    parameter int TICK_CYCLES     = CLOCK_FREQ / 1000,
    parameter int RT_WIDTH        = 10
) (
    input  logic                clk,
    input  logic                rst_in_n,
    input  logic                btn_in_n,
    input  logic                arm_in,
    input  logic                gnt_in,
    input  logic                done_in,
    input  logic                clear_in,
    output logic                req_out,
    output logic                btn_level_out,
    output logic [RT_WIDTH-1:0] rt_ms_out,
    output logic                rt_valid_out,
    output logic                won_out,
    output logic                lost_out,
    output logic                false_start_out
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TK_W = $clog2(TICK_CYCLES + 1);
    localparam logic [DB_W-1:0]     DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0]     TK_LAST = TK_W'(TICK_CYCLES - 1);
    localparam logic [RT_WIDTH-1:0] MS_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_REQ, S_WON, S_LOST, S_FOUL} state_t;

    logic                sync1_q, sync2_q;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                level_q, level_d;
    logic                level_prev_q;
    logic                press_q, press_d;
    state_t              state_q, state_d;
    logic [TK_W-1:0]     presc_q, presc_d;
    logic [RT_WIDTH-1:0] ms_q, ms_d;
    logic [RT_WIDTH-1:0] rt_q, rt_d;
    logic                rtv_q, rtv_d;
    logic                req_q, req_d;
    logic                won_q, won_d;
    logic                lost_q, lost_d;

    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (~sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = level_q & ~level_prev_q;

        state_d = state_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        rt_d    = rt_q;
        rtv_d   = rtv_q;

        if (state_q == S_ARMED) begin
            if (presc_q == TK_LAST) begin
                presc_d = '0;
                if (ms_q != MS_MAX) ms_d = ms_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // clear_in dominates every other event in the same cycle
        if (clear_in) begin
            state_d = S_IDLE;
            presc_d = '0;
            ms_d    = '0;
            rt_d    = '0;
            rtv_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef PLAYER_FALSE_START_EN
                    if (press_q) begin
                        state_d = S_FOUL;
                    end else if (arm_in) begin
                        state_d = S_ARMED;
                        presc_d = '0;
                        ms_d    = '0;
                    end
`else
                    if (arm_in) begin
                        state_d = S_ARMED;
                        presc_d = '0;
                        ms_d    = '0;
                    end
`endif
                end
                S_ARMED: begin
                    if (done_in) begin
                        state_d = S_LOST;
                    end else if (press_q) begin
                        state_d = S_REQ;
                        rt_d    = ms_q;
                        rtv_d   = 1'b1;
                    end
                end
                S_REQ: begin
                    if (gnt_in)       state_d = S_WON;
                    else if (done_in) state_d = S_LOST;
                end
                default: ;
            endcase
        end

        req_d  = (state_d == S_REQ);
        won_d  = (state_d == S_WON);
        lost_d = (state_d == S_LOST);
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            state_q      <= S_IDLE;
            presc_q      <= '0;
            ms_q         <= '0;
            rt_q         <= '0;
            rtv_q        <= 1'b0;
            req_q        <= 1'b0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            sync1_q      <= btn_in_n;
            sync2_q      <= sync1_q;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            ms_q         <= ms_d;
            rt_q         <= rt_d;
            rtv_q        <= rtv_d;
            req_q        <= req_d;
            won_q        <= won_d;
            lost_q       <= lost_d;
        end
    end

`ifdef PLAYER_FALSE_START_EN
    logic fs_q;
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) fs_q <= 1'b0;
        else           fs_q <= (state_d == S_FOUL);
    end
    assign false_start_out = fs_q;
`else
    assign false_start_out = 1'b0;
`endif

    assign req_out       = req_q;
    assign btn_level_out = level_q;
    assign rt_ms_out     = rt_q;
    assign rt_valid_out  = rtv_q;
    assign won_out       = won_q;
    assign lost_out      = lost_q;
endmodule

// File: tb/tb_player_req_ctrl.sv
// Scoreboard bench for player_req_ctrl: stimulus queues expected snapshots, a negedge monitor compares.
module tb_player_req_ctrl;
    localparam int DEB  = 4;
    localparam int TICK = 10;
    localparam int RTW  = 4;
    localparam int MSMAX = (1 << RTW) - 1;
    // raw drive -> FSM sees press edge: 2 sync + DEB debounce + 1 edge register + 1 FSM edge
    localparam int PIPE = 2 + DEB + 2;
`ifdef PLAYER_FALSE_START_EN
    localparam bit FS_EN = 1'b1;
`else
    localparam bit FS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_in_n = 1'b0, btn_in_n = 1'b1, arm_in = 1'b0, gnt_in = 1'b0, done_in = 1'b0, clear_in = 1'b0;
    logic req_out, btn_level_out, rt_valid_out, won_out, lost_out, false_start_out;
    logic [RTW-1:0] rt_ms_out;

    player_req_ctrl #(.CLOCK_FREQ(1000), .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK), .RT_WIDTH(RTW)) dut (
        .clk(clk), .rst_in_n(rst_in_n), .btn_in_n(btn_in_n), .arm_in(arm_in), .gnt_in(gnt_in),
        .done_in(done_in), .clear_in(clear_in), .req_out(req_out), .btn_level_out(btn_level_out),
        .rt_ms_out(rt_ms_out), .rt_valid_out(rt_valid_out), .won_out(won_out), .lost_out(lost_out),
        .false_start_out(false_start_out));

    always #5 clk = ~clk;

    typedef struct packed {
        logic lo; logic req; logic lvl; logic rtv; logic won; logic lost; logic fs; logic [RTW-1:0] rt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_vld = 1'b0;
    int    n_cmp = 0, n_fail = 0, cyc_n = 0;
    exp_t  mon_e;
    string mon_n;
    logic [9:0] mon_act;

    always @(negedge clk) begin
        if (chk_vld) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL monitor_underflow: output presented with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                mon_act = {req_out, btn_level_out, rt_valid_out, won_out, lost_out, false_start_out, rt_ms_out};
                if (mon_e.lo ? (mon_act[8] !== mon_e.lvl) : (mon_act !== mon_e[9:0])) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got req/lvl/rtv/won/lost/fs/rt=%b wanted %b%s", mon_n, $time,
                             mon_act, mon_e[9:0], mon_e.lo ? " (level only)" : "");
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        cyc_n++;
    endtask

    task automatic chk_st(input string nm, input logic req, lvl, rtv, won, lost, fs, input int rt);
        exp_t e;
        e = '{lo: 1'b0, req: req, lvl: lvl, rtv: rtv, won: won, lost: lost, fs: fs, rt: RTW'(rt)};
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_vld = 1'b1;
    endtask

    task automatic chk_lvl(input string nm, input logic lvl);
        exp_t e;
        e = '0;
        e.lo = 1'b1;
        e.lvl = lvl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_vld = 1'b1;
    endtask

    // whole ticks elapsed in ARMED before the FSM samples the press edge, saturated
    function automatic int exp_ms(input int arm_drv, input int press_drv);
        int t;
        t = ((press_drv + PIPE) - 1 - (arm_drv + 1)) / TICK;
        return (t > MSMAX) ? MSMAX : t;
    endfunction

    task automatic release_btn();
        btn_in_n = 1'b1;
        repeat (DEB + 4) step();
    endtask

    task automatic clear_game();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        chk_st("cleared", 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic arm_now();
        arm_in = 1'b1;
        step();
        arm_in = 1'b0;
        chk_st("armed", 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic reach_req(input int delay, output int rt);
        int a0, r;
        a0 = cyc_n;
        arm_now();
        repeat (delay) step();
        btn_in_n = 1'b0;
        r = cyc_n;
        rt = exp_ms(a0, r);
        while (cyc_n < r + PIPE - 1) step();
        chk_st("pre_req", 0, 1, 0, 0, 0, 0, 0);
        step();
        chk_st("req", 1, 1, 1, 0, 0, 0, rt);
        step();
    endtask

    task automatic game_win(input int delay, input int g, input logic wd);
        int rt;
        reach_req(delay, rt);
        repeat (g - 1) step();
        gnt_in = 1'b1;
        done_in = wd;
        step();
        gnt_in = 1'b0;
        done_in = 1'b0;
        chk_st("won", 0, 1, 1, 1, 0, 0, rt);
        step();
        done_in = 1'b1;
        arm_in = 1'b1;
        step();
        done_in = 1'b0;
        arm_in = 1'b0;
        chk_st("won_hold", 0, 1, 1, 1, 0, 0, rt);
        step();
        release_btn();
        chk_st("won_released", 0, 0, 1, 1, 0, 0, rt);
        step();
        clear_game();
    endtask

    task automatic game_loss_req(input int delay, input int g);
        int rt;
        reach_req(delay, rt);
        repeat (g - 1) step();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk_st("lost_req", 0, 1, 1, 0, 1, 0, rt);
        step();
        release_btn();
        clear_game();
    endtask

    task automatic game_loss_armed(input int delay, input logic noise);
        arm_now();
        repeat (delay) step();
        done_in = 1'b1;
        gnt_in = noise;
        step();
        done_in = 1'b0;
        gnt_in = 1'b0;
        chk_st("lost_armed", 0, 0, 0, 0, 1, 0, 0);
        step();
        btn_in_n = 1'b0;
        repeat (PIPE + 2) step();
        chk_st("lost_press_ignored", 0, 1, 0, 0, 1, 0, 0);
        step();
        release_btn();
        clear_game();
    endtask

    task automatic game_race(input int delay);
        int r;
        arm_now();
        repeat (delay) step();
        btn_in_n = 1'b0;
        r = cyc_n;
        while (cyc_n < r + PIPE - 1) step();
        chk_st("pre_race", 0, 1, 0, 0, 0, 0, 0);
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        chk_st("race_lost", 0, 1, 0, 0, 1, 0, 0);
        step();
        release_btn();
        clear_game();
    endtask

    task automatic game_clear_req(input int delay);
        int rt;
        reach_req(delay, rt);
        gnt_in = 1'b1;
        clear_in = 1'b1;
        step();
        gnt_in = 1'b0;
        clear_in = 1'b0;
        chk_st("clear_beats_gnt", 0, 1, 0, 0, 0, 0, 0);
        step();
        release_btn();
        clear_game();
    endtask

    task automatic game_reset_mid(input int delay);
        int rt;
        reach_req(delay, rt);
        rst_in_n = 1'b0;
        chk_st("async_reset", 0, 0, 0, 0, 0, 0, 0);
        step();
        btn_in_n = 1'b1;
        repeat (2) step();
        rst_in_n = 1'b1;
        repeat (DEB + 4) step();
        chk_st("post_reset", 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic game_false_start(input int delay, input int g);
        int r;
        btn_in_n = 1'b0;
        r = cyc_n;
        while (cyc_n < r + PIPE - 1) step();
        chk_st("fs_pre", 0, 1, 0, 0, 0, 0, 0);
        step();
        chk_st("fs", 0, 1, 0, 0, 0, FS_EN, 0);
        step();
        release_btn();
        chk_st("fs_released", 0, 0, 0, 0, 0, FS_EN, 0);
        step();
        if (!FS_EN) game_win(delay, g, 1'b0);
        else        clear_game();
    endtask

    task automatic bounce_test();
        for (int seg = 0; seg < 10; seg++) begin
            btn_in_n = (seg % 2 == 1);
            repeat (2) begin
                chk_lvl("bounce_glitch", 1'b0);
                step();
            end
        end
        btn_in_n = 1'b0;
        for (int i = 1; i <= 2 + DEB; i++) begin
            step();
            chk_lvl((i == 2 + DEB) ? "bounce_settle" : "bounce_early", i == 2 + DEB);
        end
        step();
        repeat (4) step();
        release_btn();
        clear_game();
    endtask

    initial begin
        repeat (3) step();
        chk_st("in_reset", 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_in_n = 1'b1;
        step();
        chk_st("after_reset", 0, 0, 0, 0, 0, 0, 0);
        step();

        bounce_test();
        game_win(27, 3, 1'b0);
        game_win(200, 2, 1'b1);
        game_race(10);
        game_loss_req(15, 2);
        game_loss_armed(30, 1'b1);
        game_false_start(12, 2);
        game_clear_req(5);
        game_reset_mid(12);

        repeat (30) begin
            int kind, d, g;
            kind = $urandom_range(0, 6);
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 220) : $urandom_range(0, 60);
            g = $urandom_range(1, 4);
            case (kind)
                0: game_win(d, g, 1'($urandom_range(0, 1)));
                1: game_loss_req(d, g);
                2: game_loss_armed(d, 1'($urandom_range(0, 1)));
                3: game_race(d);
                4: game_false_start(d % 50, g);
                5: game_clear_req(d);
                default: game_reset_mid(d);
            endcase
        end

        repeat (2) step();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL leftover_expectations: %0d still queued, wanted 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, wanted stimulus to complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
